// File: rtl/matrix_result_writer_if.sv
// Write port of the matrix result writer: one word per valid/ready transfer
// into the result memory.
interface matrix_result_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/matrix_result_writer.sv
// Write-back engine: captures a 5x5 inverse plus its diagonal scale factors
// in one cycle, then streams them into the result memory word by word.
// A zero scale factor marks the job singular and the memory write is skipped.
module matrix_result_writer #(
    parameter int DATA_W = 32,
    parameter int N      = 5,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    res_valid,
    input  logic [N*N*DATA_W-1:0]   res_flat,
    input  logic [N*DATA_W-1:0]     diag_flat,
    matrix_result_writer_if.master  wr,
    output logic                    busy,
    output logic                    done,
    output logic                    singular
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Words per job: the inverse elements followed by the scale factors.
    localparam int              NW       = N * N + N;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NW - 1);

    logic [1:0]                   state_q, state_d;
    logic [ADDR_W-1:0]            idx_q, idx_d;
    logic [N*N-1:0][DATA_W-1:0]   res_q, res_d;
    logic [N-1:0][DATA_W-1:0]     diag_q, diag_d;
    logic                         singular_q, singular_d;
    logic                         diag_zero;
    logic [DATA_W-1:0]            word;
    logic                         in_write;

    assign in_write = (state_q == S_WRITE);

    // Full-width zero test of every incoming scale factor.
    always_comb begin
        diag_zero = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (diag_flat[k*DATA_W +: DATA_W] == '0) diag_zero = 1'b1;
        end
    end

    // Select the captured word addressed by the current index.
    always_comb begin
        word = '0;
        for (int i = 0; i < N * N; i++) begin
            if (idx_q == ADDR_W'(i)) word = res_q[i];
        end
        for (int k = 0; k < N; k++) begin
            if (idx_q == ADDR_W'(N * N + k)) word = diag_q[k];
        end
    end

    // Next-state logic: capture in IDLE, stream in WRITE, one-cycle DONE.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        res_d      = res_q;
        diag_d     = diag_q;
        singular_d = singular_q;
        case (state_q)
            S_IDLE: begin
                if (res_valid) begin
                    res_d  = res_flat;
                    diag_d = diag_flat;
                    idx_d  = '0;
                    if (diag_zero) begin
                        // Status becomes visible together with done.
                        state_d    = S_DONE;
                        singular_d = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wr.wr_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = S_DONE;
                        singular_d = 1'b0;
                        idx_d      = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and capture registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            res_q      <= '0;
            diag_q     <= '0;
            singular_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            res_q      <= res_d;
            diag_q     <= diag_d;
            singular_q <= singular_d;
        end
    end

    // Outputs decode registered state only; the bus reads zero outside WRITE.
    assign wr.wr_en   = in_write;
    assign wr.wr_addr = in_write ? idx_q : '0;
    assign wr.wr_data = in_write ? word : '0;
    assign busy       = in_write;
    assign done       = (state_q == S_DONE);
    assign singular   = singular_q;

endmodule

// File: doc/matrix_result_writer.md
# matrix_result_writer

Write-back engine for the 5x5 integer matrix-inversion datapath. It captures one unnormalised inverse matrix and its five diagonal scale factors in a single cycle, then writes them word by word into a 32-entry result memory over a valid/ready write port. The write port is the opposite direction of the ROM read port that loads the source matrix. The block also flags singular results and skips the memory write for them.

## Interface

Parameters:
- DATA_W, 32, width of every matrix element and memory word
- N, 5, matrix dimension; fixed at 5 in this design
- ADDR_W, 5, result memory address width (32 locations)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- res_valid  input  1  single-cycle strobe; result buses valid this cycle
- res_flat  input  N*N*DATA_W  inverse elements, row-major; element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W], r,c from 0
- diag_flat  input  N*DATA_W  final pivot/scale values d0..d4; dk at bits [k*DATA_W +: DATA_W]
- wr_ready  input  1  memory accepts the presented word this cycle
- wr_en  output  1  write request; word presented
- wr_addr  output  ADDR_W  write address
- wr_data  output  DATA_W  write data
- busy  output  1  high while in WRITE
- done  output  1  one-cycle completion pulse
- singular  output  1  status of the last completed job; holds until the next job completes

## Operation

- States: IDLE, WRITE, DONE.
- IDLE with res_valid=1: capture res_flat and diag_flat into internal registers.
  - If any dk == 0, go to DONE with singular_next=1.
  - Otherwise go to WRITE with word index 0 and singular_next=0.
- WRITE presents words in this order: index 0..24 = inverse elements (r,c) in row-major order; index 25..29 = d0..d4. wr_addr = index; wr_data = the selected word.
- A word transfers when wr_en && wr_ready. On transfer the index increments. On transfer of index 29 the next state is DONE.
- wr_en=1 for every WRITE cycle. wr_addr and wr_data hold stable while wr_ready=0.
- DONE lasts exactly one cycle: done=1 and singular updates to singular_next. Next state is IDLE.
- res_valid outside IDLE is ignored; the captured data is not disturbed.
- All values are treated as unsigned 32-bit words. No arithmetic is performed on data. The zero test is a full-width compare.
- Addresses 30 and 31 are never written.

## Timing

- Reset (asynchronous assert, synchronous-to-clk deassert use) forces:
  - state IDLE, index 0
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, singular=0
  - capture registers 0
- Reset mid-WRITE aborts the job. No resumption. Memory contents already written are left as they are.
- All outputs are registered or decoded from registered state. No combinational path from wr_ready to wr_en/wr_addr/wr_data.
- res_valid sampled at edge T (nonsingular job):
  - cycle T+1: WRITE, wr_en=1, wr_addr=0, busy=1
  - with wr_ready held 1: addresses 0..29 in cycles T+1..T+30
  - DONE (done=1, busy=0) in T+31
  - IDLE in T+32; a new res_valid is accepted at T+32
- Each wr_ready=0 cycle in WRITE delays completion by one cycle.
- Singular job: DONE at T+1 (done=1, singular=1), wr_en never asserted, IDLE at T+2.
- res_valid coincident with the DONE cycle is ignored.

## Test plan

- Identity result, diag all 1, wr_ready=1 -> 30 writes in 30 consecutive cycles; addr 0,6,12,18,24 = 1; other addr 0..24 = 0; addr 25..29 = 1; done at T+31; singular=0.
- Distinct pattern res(r,c)=r*16+c, diag={7,8,9,10,11} -> memory[r*5+c]=r*16+c, memory[25..29]=7..11; no address 30/31 write.
- wr_ready toggling 1,0,0,1 repeating -> each word held stable across stalls; exact 30-word sequence with no duplicates or skips; done follows the last accepted word by one cycle.
- diag d3=0 -> no wr_en; done and singular=1 at T+1. A following nonsingular job -> singular returns to 0 at its done.
- res_valid re-pulsed at addr 10 with different data -> ignored; remaining words come from the first capture.
- reset low at addr 15 -> all outputs 0 immediately. After release, a fresh res_valid restarts writing at addr 0.
